vram_port_arb: RTL

Two-requester arbiter that shares the single PS memory port (mem_if_sys user side) between the HDMI capture writer (line_buf_in bursts) and the VGA display reader (v480p_24b_out line fetches). It runs in the FCLK_CLK0 domain. Display reads get priority, with a bounded-run rule so capture writes never starve. It computes read addresses from line/VRAM numbers and sequences one memory transaction at a time.

---
 rtl/vram_port_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vram_port_arb.sv
// Shares the single memory port between capture write bursts and display line reads.
// Define VRAM_ARB_TIMEOUT_EN to add a per-transaction watchdog driving a sticky err_o.
module vram_port_arb #(
  parameter int unsigned ADR_W      = 22,
  parameter int unsigned WR_LEN     = 8,
  parameter int unsigned LINE_WORDS = 640,
  parameter int unsigned RD_RUN_MAX = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_req_i,
  input  logic [ADR_W-1:0] wr_adr_i,
  output logic             wr_ack_o,
  output logic             wr_done_o,
  input  logic             rd_req_i,
  input  logic [11:0]      rd_line_no_i,
  input  logic [1:0]       rd_vram_no_i,
  output logic             rd_ack_o,
  output logic             rd_done_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic [9:0]       mem_len_o,
  input  logic             mem_ack_i,
  input  logic             mem_done_i,
  output logic             err_o
);

  localparam int unsigned     RunW   = (RD_RUN_MAX < 1) ? 1 : $clog2(RD_RUN_MAX + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(RD_RUN_MAX);
  localparam logic [9:0]      RdLen  = 10'(LINE_WORDS);
  localparam logic [9:0]      WrLen  = 10'(WR_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

  state_e           state_q;
  logic             owner_rd_q;
  logic [RunW-1:0]  rd_run_q;
  logic             wr_ack_q, wr_done_q, rd_ack_q, rd_done_q;
  logic             mem_req_q, mem_we_q;
  logic [ADR_W-1:0] mem_adr_q;
  logic [9:0]       mem_len_q;

  logic             grant_rd;
  logic [ADR_W-1:0] rd_adr;
  logic [RunW-1:0]  rd_run_inc;
  logic             to_hit;

  assign rd_adr = ADR_W'({rd_vram_no_i, 20'b0}) + ADR_W'(rd_line_no_i) * ADR_W'(LINE_WORDS);
  // Reads win unless a write has already waited out RD_RUN_MAX consecutive reads.
  assign grant_rd   = rd_req_i && (!wr_req_i || (rd_run_q < RunMax));
  assign rd_run_inc = (rd_run_q == RunMax) ? rd_run_q : rd_run_q + 1'b1;

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int unsigned    ToW    = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  // >= so a timeout landing on the mem_ack cycle still fires one cycle later in BUSY.
  assign to_hit = (to_cnt_q >= ToLast);
  assign err_o  = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      owner_rd_q <= 1'b0;
      rd_run_q   <= '0;
      wr_ack_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_len_q  <= '0;
`ifdef VRAM_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      wr_ack_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_done_q <= 1'b0;
`ifdef VRAM_ARB_TIMEOUT_EN
      to_cnt_q  <= (state_q == StIdle) ? '0 : to_cnt_q + 1'b1;
`endif
      case (state_q)
        StIdle: begin
          if (grant_rd) begin
            state_q    <= StReq;
            owner_rd_q <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= rd_adr;
            mem_len_q  <= RdLen;
            rd_run_q   <= wr_req_i ? rd_run_inc : '0;
          end else if (wr_req_i) begin
            state_q    <= StReq;
            owner_rd_q <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_adr_q  <= wr_adr_i;
            mem_len_q  <= WrLen;
            rd_run_q   <= '0;
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            rd_ack_q  <= owner_rd_q;
            wr_ack_q  <= !owner_rd_q;
            if (mem_done_i) begin
              rd_done_q <= owner_rd_q;
              wr_done_q <= !owner_rd_q;
              state_q   <= StIdle;
            end else begin
              state_q   <= StBusy;
            end
          end else if (to_hit) begin
            mem_req_q <= 1'b0;
            rd_done_q <= owner_rd_q;
            wr_done_q <= !owner_rd_q;
            state_q   <= StIdle;
`ifdef VRAM_ARB_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
          end
        end
        StBusy: begin
          if (mem_done_i || to_hit) begin
            rd_done_q <= owner_rd_q;
            wr_done_q <= !owner_rd_q;
            state_q   <= StIdle;
`ifdef VRAM_ARB_TIMEOUT_EN
            if (!mem_done_i) err_q <= 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_ack_o  = wr_ack_q;
  assign wr_done_o = wr_done_q;
  assign rd_ack_o  = rd_ack_q;
  assign rd_done_o = rd_done_q;
  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_len_o = mem_len_q;

endmodule
